// File: rtl/button_pkg.sv
// Shared types, default timing and helpers for the button debounce/auto-repeat block.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONFIRM  = 3'd1,
    HELD     = 3'd2,
    BLIP     = 3'd3,
    REL_CONF = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_WIDTH           = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms @ 50 MHz
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000;  // 0.5 s before first repeat
  localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;  // 0.2 s between repeats
  localparam int unsigned DEF_PULSE_CYCLES    = 2;

  // Counter must hold the largest terminal value without wrapping.
  function automatic int unsigned cnt_width(input int unsigned deb,
                                            input int unsigned hold,
                                            input int unsigned rep,
                                            input int unsigned pulse);
    int unsigned m;
    m = deb;
    if (hold  > m) m = hold;
    if (rep   > m) m = rep;
    if (pulse > m) m = pulse;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce_repeat_if.sv
// Button bundle between the raw pads and the PIO-facing conditioned outputs.
interface button_debounce_repeat_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] btn_n_in;
  logic [WIDTH-1:0] btn_n_out;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] press_pulse;

  modport master (
    output btn_n_in,
    input  btn_n_out,
    input  pressed,
    input  press_pulse
  );

  modport slave (
    input  btn_n_in,
    output btn_n_out,
    output pressed,
    output press_pulse
  );

endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM with hold-to-repeat, registered outputs.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn_n,
  output logic o_btn_n,
  output logic o_pressed,
  output logic o_press_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES,
                                            REPEAT_CYCLES, PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_hold_last;
  logic             r_rep;
  logic             w_rep_nxt;
  logic             r_evt;
  logic             w_evt_nxt;
  logic             w_btn_n_d;
  logic             w_pressed_d;
  logic             w_pulse_d;

  // Synchronizer idles released so a held button after reset needs a fresh debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rep   <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rep   <= w_rep_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hold_last = r_rep ? REP_LAST : HOLD_LAST;

  // Input changes are tested before timer expiry in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_rep_nxt   = r_rep;
    w_evt_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = CONFIRM;
      end
      CONFIRM: begin
        if (r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rep_nxt   = 1'b0;
          w_evt_nxt   = 1'b1;
        end
      end
      HELD: begin
        if (r_sync2) begin
          w_state_nxt = REL_CONF;
          w_cnt_nxt   = '0;
        end else if (REPEAT_EN && (r_cnt == w_hold_last)) begin
          w_state_nxt = BLIP;
          w_cnt_nxt   = '0;
        end
      end
      BLIP: begin
        if (r_sync2) begin
          w_state_nxt = REL_CONF;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PULSE_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rep_nxt   = 1'b1;
          w_evt_nxt   = 1'b1;
        end
      end
      REL_CONF: begin
        if (!r_sync2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_rep_nxt   = 1'b0;
      end
    endcase
  end

  // Output levels decode the current state; press strobe follows the accepting transition.
  always_comb begin
    w_btn_n_d   = 1'b1;
    w_pressed_d = 1'b0;
    w_pulse_d   = r_evt;
    unique case (r_state)
      HELD, REL_CONF: begin
        w_btn_n_d   = 1'b0;
        w_pressed_d = 1'b1;
      end
      BLIP: begin
        w_btn_n_d   = 1'b1;
        w_pressed_d = 1'b1;
      end
      default: begin
        w_btn_n_d   = 1'b1;
        w_pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_btn_n       <= 1'b1;
      o_pressed     <= 1'b0;
      o_press_pulse <= 1'b0;
    end else begin
      o_btn_n       <= w_btn_n_d;
      o_pressed     <= w_pressed_d;
      o_press_pulse <= w_pulse_d;
    end
  end

endmodule

// File: rtl/button_debounce_repeat.sv
// Conditions WIDTH raw active-low buttons into clean PIO-ready edges, one channel per bit.
module button_debounce_repeat
  import button_pkg::*;
#(
  parameter int unsigned      WIDTH           = DEF_WIDTH,
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned      HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned      REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned      PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter logic [WIDTH-1:0] REPEAT_EN       = {WIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset_n,
  button_debounce_repeat_if.slave  bus
);

  logic [WIDTH-1:0] w_btn_n_out;
  logic [WIDTH-1:0] w_pressed;
  logic [WIDTH-1:0] w_press_pulse;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES),
      .REPEAT_EN       (REPEAT_EN[i])
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_btn_n       (bus.btn_n_in[i]),
      .o_btn_n       (w_btn_n_out[i]),
      .o_pressed     (w_pressed[i]),
      .o_press_pulse (w_press_pulse[i])
    );
  end

  assign bus.btn_n_out   = w_btn_n_out;
  assign bus.pressed     = w_pressed;
  assign bus.press_pulse = w_press_pulse;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench: bounce, clean press, auto-repeat, repeat mask, release glitch, reset mid-blip.
module tb_button_debounce_repeat;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   pulse_tot;
  int   low_tot;

  button_debounce_repeat_if #(.WIDTH(8)) bus ();

  button_debounce_repeat #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (10),
    .PULSE_CYCLES    (2),
    .REPEAT_EN       (8'h01)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running totals used to prove that nothing happened over a window.
  always @(negedge clk) begin
    if (reset_n) begin
      pulse_tot = pulse_tot + $countones(bus.press_pulse);
      if (bus.btn_n_out !== 8'hFF) low_tot = low_tot + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.btn_n_in = 8'hFF;
    step(15);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.btn_n_in = 8'hFF;
    step(3);
    checks++;
    if (bus.btn_n_out !== 8'hFF || bus.pressed !== 8'h00 || bus.press_pulse !== 8'h00) begin
      failures++;
      $display("FAIL reset_values out=%h pressed=%h pulse=%h exp out=ff pressed=00 pulse=00",
               bus.btn_n_out, bus.pressed, bus.press_pulse);
    end
    reset_n = 1'b1;
    step(5);
    checks++;
    if (bus.btn_n_out !== 8'hFF || bus.pressed !== 8'h00 || bus.press_pulse !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle out=%h pressed=%h pulse=%h exp out=ff pressed=00 pulse=00",
               bus.btn_n_out, bus.pressed, bus.press_pulse);
    end
  endtask

  task automatic test_bounce();
    int p0;
    int l0;
    p0 = pulse_tot;
    l0 = low_tot;
    for (int i = 0; i < 16; i++) begin
      bus.btn_n_in[0] = ((i / 2) % 2) != 0;
      step(1);
    end
    bus.btn_n_in[0] = 1'b1;
    step(12);
    checks++;
    if (pulse_tot - p0 !== 0) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d exp=0", pulse_tot - p0);
    end
    checks++;
    if (low_tot - l0 !== 0) begin
      failures++;
      $display("FAIL bounce_out_low_cycles got=%0d exp=0", low_tot - l0);
    end
    checks++;
    if (bus.btn_n_out !== 8'hFF || bus.pressed !== 8'h00) begin
      failures++;
      $display("FAIL bounce_final out=%h pressed=%h exp ff/00", bus.btn_n_out, bus.pressed);
    end
  endtask

  task automatic test_clean_press();
    logic e_out;
    logic e_pls;
    bus.btn_n_in[0] = 1'b0;
    for (int c = 0; c < 26; c++) begin
      step(1);
      e_out = (c <= 6) || (c >= 22);
      e_pls = (c == 7);
      checks++;
      if (bus.btn_n_out[0] !== e_out || bus.pressed[0] !== !e_out || bus.press_pulse[0] !== e_pls) begin
        failures++;
        $display("FAIL clean_press c=%0d out=%b pressed=%b pulse=%b exp out=%b pressed=%b pulse=%b",
                 c, bus.btn_n_out[0], bus.pressed[0], bus.press_pulse[0], e_out, !e_out, e_pls);
      end
      if (c == 14) bus.btn_n_in[0] = 1'b1;
    end
  endtask

  task automatic test_auto_repeat();
    logic e_out;
    logic e_pls;
    int   p0;
    p0 = pulse_tot;
    bus.btn_n_in[0] = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step(1);
      e_out = (c <= 6) || (c >= 27 && c <= 28) || (c >= 39 && c <= 40) ||
              (c >= 51 && c <= 52) || (c >= 65);
      e_pls = (c == 7) || (c == 29) || (c == 41) || (c == 53);
      checks++;
      if (bus.btn_n_out[0] !== e_out || bus.press_pulse[0] !== e_pls) begin
        failures++;
        $display("FAIL auto_repeat c=%0d out=%b pulse=%b exp out=%b pulse=%b",
                 c, bus.btn_n_out[0], bus.press_pulse[0], e_out, e_pls);
      end
      if (c == 57) bus.btn_n_in[0] = 1'b1;
    end
    step(1);
    checks++;
    if (pulse_tot - p0 !== 4) begin
      failures++;
      $display("FAIL auto_repeat_pulse_count got=%0d exp=4", pulse_tot - p0);
    end
  endtask

  // Channels 1 and 2 have repeat masked off and are pressed together.
  task automatic test_mask();
    logic       e_out;
    logic       e_pls;
    logic [7:0] e_vec;
    bus.btn_n_in[2:1] = 2'b00;
    for (int c = 0; c < 70; c++) begin
      step(1);
      e_out = (c <= 6) || (c >= 65);
      e_pls = (c == 7);
      e_vec = {5'h1F, e_out, e_out, 1'b1};
      checks++;
      if (bus.btn_n_out !== e_vec || bus.press_pulse !== {5'h00, e_pls, e_pls, 1'b0}) begin
        failures++;
        $display("FAIL mask c=%0d out=%h pulse=%h exp out=%h pulse=%h",
                 c, bus.btn_n_out, bus.press_pulse, e_vec, {5'h00, e_pls, e_pls, 1'b0});
      end
      if (c == 57) bus.btn_n_in[2:1] = 2'b11;
    end
  endtask

  task automatic test_release_glitch();
    logic e_out;
    logic e_prs;
    logic e_pls;
    bus.btn_n_in[0] = 1'b0;
    for (int c = 0; c < 52; c++) begin
      step(1);
      e_out = (c <= 6) || (c >= 37 && c <= 38) || (c >= 48);
      e_prs = (c >= 7) && (c <= 47);
      e_pls = (c == 7) || (c == 39);
      checks++;
      if (bus.btn_n_out[0] !== e_out || bus.pressed[0] !== e_prs || bus.press_pulse[0] !== e_pls) begin
        failures++;
        $display("FAIL release_glitch c=%0d out=%b pressed=%b pulse=%b exp out=%b pressed=%b pulse=%b",
                 c, bus.btn_n_out[0], bus.pressed[0], bus.press_pulse[0], e_out, e_prs, e_pls);
      end
      if (c == 10) bus.btn_n_in[0] = 1'b1;
      if (c == 13) bus.btn_n_in[0] = 1'b0;
      if (c == 40) bus.btn_n_in[0] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_blip();
    logic e_out;
    logic e_pls;
    bus.btn_n_in[0] = 1'b0;
    step(28);
    checks++;
    if (bus.btn_n_out[0] !== 1'b1 || bus.pressed[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_blip out=%b pressed=%b exp out=1 pressed=1",
               bus.btn_n_out[0], bus.pressed[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.btn_n_out !== 8'hFF || bus.pressed !== 8'h00 || bus.press_pulse !== 8'h00) begin
      failures++;
      $display("FAIL reset_immediate out=%h pressed=%h pulse=%h exp ff/00/00",
               bus.btn_n_out, bus.pressed, bus.press_pulse);
    end
    step(3);
    checks++;
    if (bus.btn_n_out !== 8'hFF || bus.pressed !== 8'h00 || bus.press_pulse !== 8'h00) begin
      failures++;
      $display("FAIL reset_held out=%h pressed=%h pulse=%h exp ff/00/00",
               bus.btn_n_out, bus.pressed, bus.press_pulse);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(1);
      e_out = (c <= 6);
      e_pls = (c == 7);
      checks++;
      if (bus.btn_n_out[0] !== e_out || bus.press_pulse[0] !== e_pls) begin
        failures++;
        $display("FAIL after_reset c=%0d out=%b pulse=%b exp out=%b pulse=%b",
                 c, bus.btn_n_out[0], bus.press_pulse[0], e_out, e_pls);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    pulse_tot    = 0;
    low_tot      = 0;
    reset_n      = 1'b0;
    bus.btn_n_in = 8'hFF;
    test_reset();
    test_bounce();
    go_idle();
    test_clean_press();
    go_idle();
    test_auto_repeat();
    go_idle();
    test_mask();
    go_idle();
    test_release_glitch();
    go_idle();
    test_reset_mid_blip();
    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
